seq_mul_core: RTL

- Datapath and iteration counter for the sequential (shift-and-add) multiplier.
- Consumes the level run-enable from the multiplier's start/stop control flop.
- Returns the terminal-count strobe `tc` that clears that enable.
- One multiply costs exactly WIDTH enabled cycles; the product is held until the next load.

---
 rtl/seq_mul_pkg.sv | 17 +
 rtl/seq_mul_cnt.sv | 32 +++
 rtl/seq_mul_core.sv | 122 ++++++++++++
 3 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package seq_mul_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/seq_mul_cnt.sv
// Iteration counter: synchronous clear, enable, and a flag for the final iteration.
module seq_mul_cnt
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/seq_mul_core.sv
// Sequential multiplier datapath + FSM; one iteration per enabled cycle, WIDTH iterations total.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands via radix-2 Booth recoding.
module seq_mul_core
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               run,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               tc,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d, acc_q, acc_d, q_q, q_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     sum;
  logic               active, last, step;
`ifdef SEQ_MUL_SIGNED_EN
  logic               q1_q, q1_d;
  logic [WIDTH:0]     acc_x, m_x;
`else
  logic               c_q, c_d;
`endif

  seq_mul_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (load),
    .en_i   (step),
    .last_o (last)
  );

  // Sum is one bit wider than the accumulator so the shift pulls its top bit into A.
`ifdef SEQ_MUL_SIGNED_EN
  always_comb begin
    acc_x = {acc_q[WIDTH-1], acc_q};
    m_x   = {m_q[WIDTH-1], m_q};
    case ({q_q[0], q1_q})
      2'b10:   sum = acc_x - m_x;
      2'b01:   sum = acc_x + m_x;
      default: sum = acc_x;
    endcase
  end
`else
  assign sum = q_q[0] ? ({1'b0, acc_q} + {1'b0, m_q}) : {c_q, acc_q};
`endif

  assign active = (state_q == ARMED) || (state_q == SHIFT);
  assign step   = run && active && !load;
  assign tc     = step && last;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    done_d  = done_q;
`ifdef SEQ_MUL_SIGNED_EN
    q1_d    = q1_q;
`else
    c_d     = c_q;
`endif
    if (load) begin
      state_d = ARMED;
      m_d     = a;
      acc_d   = '0;
      q_d     = b;
      done_d  = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      q1_d    = 1'b0;
`else
      c_d     = 1'b0;
`endif
    end else if (step) begin
      acc_d   = sum[WIDTH:1];
      q_d     = {sum[0], q_q[WIDTH-1:1]};
`ifdef SEQ_MUL_SIGNED_EN
      q1_d    = q_q[0];
`else
      c_d     = 1'b0;
`endif
      state_d = last ? DONE : SHIFT;
      if (last) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      q1_q    <= 1'b0;
`else
      c_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      done_q  <= done_d;
`ifdef SEQ_MUL_SIGNED_EN
      q1_q    <= q1_d;
`else
      c_q     <= c_d;
`endif
    end
  end

  assign product = {acc_q, q_q};
  assign done    = done_q;

endmodule
